// File: rtl/programmable_truth_table.sv
// Registered, serially reprogrammable N_IN-input / N_OUT-output truth table with a 1-stage valid/ready eval.
// Optional feature macro: TT_PARITY_EN (adds an even-parity bit to each load and the cfg_err port).
module programmable_truth_table #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 1,
    parameter logic [N_OUT*(2**N_IN)-1:0] RESET_TT = (N_OUT*(2**N_IN))'(8'h66)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_vec,
    input  logic             cfg_start,
    input  logic             cfg_bvalid,
    input  logic             cfg_bit,
    output logic             cfg_busy,
`ifdef TT_PARITY_EN
    output logic             cfg_err,
`endif
    output logic             cfg_done
);

    localparam int unsigned DEPTH   = 2**N_IN;
    localparam int unsigned TT_BITS = N_OUT * DEPTH;
`ifdef TT_PARITY_EN
    localparam int unsigned LOAD_BITS = TT_BITS + 1;
`else
    localparam int unsigned LOAD_BITS = TT_BITS;
`endif
    localparam int unsigned CNT_W = $clog2(LOAD_BITS + 1);
    localparam int unsigned IDX_W = $clog2(TT_BITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LOAD_BITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                          state;
    logic [CNT_W-1:0]                count;
    logic [TT_BITS-1:0]              shadow;
    logic [TT_BITS-1:0]              active_tt;
    logic [N_OUT-1:0][DEPTH-1:0]     tt_rows;
    logic [N_OUT-1:0]                eval_c;
    logic                            drain_c;
`ifdef TT_PARITY_EN
    logic                            par_bit;
`endif

    // Pipeline can drain when nothing is held or the held result leaves this cycle.
    assign drain_c  = !out_valid || out_ready;
    assign in_ready = drain_c && (state != COMMIT);
    assign cfg_busy = (state != IDLE);

    // One row of the active table per output; the input vector selects the column.
    assign tt_rows = active_tt;
    always_comb begin
        eval_c = '0;
        for (int j = 0; j < N_OUT; j++) begin
            eval_c[j] = tt_rows[j][in_vec];
        end
    end

    // Eval stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_vec   <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_vec   <= eval_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Serial loader; a commit waits for the eval stage to drain so no result mixes tables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            shadow    <= '0;
            active_tt <= RESET_TT;
            cfg_done  <= 1'b0;
`ifdef TT_PARITY_EN
            cfg_err   <= 1'b0;
            par_bit   <= 1'b0;
`endif
        end else begin
            cfg_done <= 1'b0;
`ifdef TT_PARITY_EN
            cfg_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state <= LOAD;
                        count <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        count <= '0;
                    end else if (cfg_bvalid) begin
`ifdef TT_PARITY_EN
                        if (count == LAST) begin
                            par_bit <= cfg_bit;
                        end else begin
                            shadow[count[IDX_W-1:0]] <= cfg_bit;
                        end
`else
                        shadow[count[IDX_W-1:0]] <= cfg_bit;
`endif
                        count <= count + CNT_W'(1);
                        if (count == LAST) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    if (cfg_start) begin
                        state <= LOAD;
                        count <= '0;
                    end else if (drain_c) begin
`ifdef TT_PARITY_EN
                        if ((^shadow) == par_bit) begin
                            active_tt <= shadow;
                            cfg_done  <= 1'b1;
                        end else begin
                            cfg_err   <= 1'b1;
                        end
`else
                        active_tt <= shadow;
                        cfg_done  <= 1'b1;
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_programmable_truth_table.sv
// Self-checking bench for programmable_truth_table: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_programmable_truth_table;

    localparam int unsigned TT_BITS = 8;
`ifdef TT_PARITY_EN
    localparam int unsigned LOAD_BITS = TT_BITS + 1;
`else
    localparam int unsigned LOAD_BITS = TT_BITS;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_bvalid = 1'b0;
    logic       cfg_bit = 1'b0;
    logic [2:0] in_vec = 3'd0;
    logic       in_ready;
    logic       out_valid;
    logic [0:0] out_vec;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    programmable_truth_table dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vec    (out_vec),
        .cfg_start  (cfg_start),
        .cfg_bvalid (cfg_bvalid),
        .cfg_bit    (cfg_bit),
        .cfg_busy   (cfg_busy),
`ifdef TT_PARITY_EN
        .cfg_err    (cfg_err),
`endif
        .cfg_done   (cfg_done)
    );
`ifndef TT_PARITY_EN
    assign cfg_err = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a table value, a list of received config bits and two phase flags.
    bit [7:0] m_tt;
    bit       m_ov, m_ovec, m_loading, m_commit, m_done, m_err;
    bit       q[$];
    bit       m_drain;
    bit [7:0] m_new;
    int       m_ones;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tt = 8'h66; m_ov = 0; m_ovec = 0;
            m_loading = 0; m_commit = 0; m_done = 0; m_err = 0;
            q.delete();
        end else begin
            m_drain = !m_ov || out_ready;
            if (in_valid && m_drain && !m_commit) begin
                m_ov = 1;
                m_ovec = m_tt[in_vec];
            end else if (out_ready) begin
                m_ov = 0;
            end
            m_done = 0;
            m_err  = 0;
            if (cfg_start) begin
                m_loading = 1; m_commit = 0; q.delete();
            end else if (m_loading) begin
                if (cfg_bvalid) begin
                    q.push_back(cfg_bit);
                    if (q.size() == LOAD_BITS) begin
                        m_loading = 0; m_commit = 1;
                    end
                end
            end else if (m_commit && m_drain) begin
                m_new = 0; m_ones = 0;
                for (int i = 0; i < TT_BITS; i++) begin
                    m_new[i] = q[i];
                    m_ones += int'(q[i]);
                end
                m_commit = 0;
                if (LOAD_BITS > TT_BITS && ((m_ones + int'(q[TT_BITS])) % 2) != 0) m_err = 1;
                else begin m_tt = m_new; m_done = 1; end
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) chk("out_vec", 32'(out_vec), 32'(m_ovec));
            chk("in_ready", 32'(in_ready), 32'((!m_ov || out_ready) && !m_commit));
            chk("cfg_busy", 32'(cfg_busy), 32'(m_loading || m_commit));
            chk("cfg_done", 32'(cfg_done), 32'(m_done));
            chk("cfg_err", 32'(cfg_err), 32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic eval_lit(input logic [2:0] v, input logic exp, input string name);
        in_valid = 1; in_vec = v; out_ready = 1;
        step();
        in_valid = 0;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk(name, 32'(out_vec), 32'(exp));
    endtask

    task automatic load_bits(input logic [7:0] tt, input logic par);
        cfg_start = 1;
        step();
        cfg_start = 0;
        cfg_bvalid = 1;
        for (int i = 0; i < TT_BITS; i++) begin
            cfg_bit = tt[i];
            step();
            chk("busy_during_load", 32'(cfg_busy), 32'd1);
        end
        if (LOAD_BITS > TT_BITS) begin
            cfg_bit = par;
            step();
            chk("busy_parity_bit", 32'(cfg_busy), 32'd1);
        end
        cfg_bvalid = 0;
    endtask

    task automatic wait_done(input int max, output int dones, output int errs);
        dones = 0; errs = 0;
        for (int k = 0; k < max; k++) begin
            step();
            if (cfg_done) dones++;
            if (cfg_err) errs++;
        end
    endtask

    int       d, e;
    logic [7:0] t66;

    initial begin
        t66 = 8'h66;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_vec", 32'(out_vec), 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        chk("rst_done", 32'(cfg_done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        eval_lit(3'b001, 1'b1, "rst_tt_001");
        eval_lit(3'b011, 1'b0, "rst_tt_011");
        eval_lit(3'b110, 1'b1, "rst_tt_110");

`ifdef TT_PARITY_EN
        load_bits(8'h96, 1'b1);
        wait_done(4, d, e);
        chk("bad_par_done", 32'(d), 32'd0);
        chk("bad_par_err", 32'(e), 32'd1);
        eval_lit(3'b111, 1'b0, "bad_par_tt_111");
`endif

        load_bits(8'h96, 1'b0);
        wait_done(4, d, e);
        chk("load96_done_once", 32'(d), 32'd1);
        eval_lit(3'b111, 1'b1, "tt96_111");
        eval_lit(3'b011, 1'b0, "tt96_011");

        // Backpressure: held result stays put while downstream stalls.
        out_ready = 1; in_valid = 1; in_vec = 3'd2;
        step();
        out_ready = 0; in_vec = 3'd4;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_vec", 32'(out_vec), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1; in_vec = 3'd5;
        step();
        in_valid = 0;
        chk("bp_next_vec", 32'(out_vec), 32'd0);
        chk("bp_next_valid", 32'(out_valid), 32'd1);

        // Commit while the output is stalled must wait for the handshake.
        in_valid = 1; in_vec = 3'd7;
        step();
        in_valid = 0; out_ready = 0;
        load_bits(8'h69, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_no_done", 32'(cfg_done), 32'd0);
            chk("stall_old_vec", 32'(out_vec), 32'd1);
        end
        out_ready = 1;
        step();
        chk("stall_done_after_ready", 32'(cfg_done), 32'd1);
        eval_lit(3'b111, 1'b0, "tt69_111");
        eval_lit(3'b000, 1'b1, "tt69_000");

        // Restart after four bits, then a full load.
        cfg_start = 1;
        step();
        cfg_start = 0; cfg_bvalid = 1; cfg_bit = 1;
        repeat (4) step();
        cfg_bvalid = 0;
        load_bits(8'h5A, 1'b0);
        wait_done(4, d, e);
        chk("restart_done_once", 32'(d), 32'd1);
        eval_lit(3'b001, 1'b1, "tt5a_001");
        eval_lit(3'b010, 1'b0, "tt5a_010");
        eval_lit(3'b110, 1'b1, "tt5a_110");

        // Reset mid-load restores the power-on table.
        cfg_start = 1;
        step();
        cfg_start = 0; cfg_bvalid = 1; cfg_bit = 0;
        repeat (3) step();
        cfg_bvalid = 0;
        rst_n = 0;
        step();
        chk("midrst_busy", 32'(cfg_busy), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        step();
        rst_n = 1;
        for (int i = 0; i < 8; i++) eval_lit(3'(i), t66[i], "midrst_tt66");

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_vec     = 3'($urandom_range(0, 7));
            out_ready  = ($urandom_range(0, 9) < 7);
            cfg_start  = ($urandom_range(0, 59) == 0);
            cfg_bvalid = 1'($urandom_range(0, 1));
            cfg_bit    = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 0; cfg_start = 0; cfg_bvalid = 0; out_ready = 1;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
